// File: rtl/status_reporter.sv
// Serialises one 32-bit status word as 4 UART bytes, MSB byte first, 8N1, LSB bit first.
// Optional build macro STATUS_REPORTER_CHECKSUM_EN appends an XOR checksum byte.
module status_reporter #(
  parameter int unsigned BAUD_CYCLES   = 434,
  parameter int unsigned IDLE_GAP_BITS = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic [31:0] i_data,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_uart_tx
);

`ifdef STATUS_REPORTER_CHECKSUM_EN
  localparam int unsigned N_BYTES = 5;
`else
  localparam int unsigned N_BYTES = 4;
`endif
  localparam int unsigned SHW = N_BYTES * 8;
  localparam int unsigned CW  = $clog2(BAUD_CYCLES);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(BAUD_CYCLES - 2);
  localparam logic [3:0]    GAP_LAST  = 4'(IDLE_GAP_BITS - 1);
  localparam logic [2:0]    BYTE_LAST = 3'(N_BYTES - 1);
  localparam logic          HAS_GAP   = (IDLE_GAP_BITS != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t         state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [2:0]     byte_idx;
  logic [3:0]     gap_cnt;
  logic [SHW-1:0] shreg;
  logic [SHW-1:0] load_word;
  logic [7:0]     cur_byte;
  logic           bit_end;
  logic           last_bit_time;
  logic           finish_now;

`ifdef STATUS_REPORTER_CHECKSUM_EN
  assign load_word = {i_data, i_data[31:24] ^ i_data[23:16] ^ i_data[15:8] ^ i_data[7:0]};
`else
  assign load_word = i_data;
`endif

  assign cur_byte = shreg[SHW-1 -: 8];
  assign bit_end  = (baud_cnt == CNT_LAST);

  // Finishing one cycle early lets o_ready/o_done coincide with the final bit-time cycle,
  // so a new word accepted on the next edge starts its start bit with no idle gap.
  assign last_bit_time = (byte_idx == BYTE_LAST) &&
                         (((state == S_STOP) && !HAS_GAP) ||
                          ((state == S_GAP) && (gap_cnt == GAP_LAST)));
  assign finish_now    = last_bit_time && (baud_cnt == CNT_PRE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      o_done <= 1'b0;
      if (state != S_IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
      end

      if (finish_now) begin
        state    <= S_IDLE;
        baud_cnt <= '0;
        byte_idx <= '0;
        o_ready  <= 1'b1;
        o_done   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_stb) begin
              shreg     <= load_word;
              byte_idx  <= '0;
              baud_cnt  <= '0;
              o_ready   <= 1'b0;
              o_uart_tx <= 1'b0;
              state     <= S_START;
            end
          end
          S_START: begin
            if (bit_end) begin
              bit_idx   <= '0;
              o_uart_tx <= cur_byte[0];
              state     <= S_DATA;
            end
          end
          S_DATA: begin
            if (bit_end) begin
              if (bit_idx == 3'd7) begin
                o_uart_tx <= 1'b1;
                shreg     <= {shreg[SHW-9:0], 8'h00};
                state     <= S_STOP;
              end else begin
                bit_idx   <= bit_idx + 3'd1;
                o_uart_tx <= cur_byte[bit_idx + 3'd1];
              end
            end
          end
          S_STOP: begin
            if (bit_end) begin
              if (HAS_GAP) begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end else begin
                byte_idx  <= byte_idx + 3'd1;
                o_uart_tx <= 1'b0;
                state     <= S_START;
              end
            end
          end
          S_GAP: begin
            if (bit_end) begin
              if (gap_cnt == GAP_LAST) begin
                byte_idx  <= byte_idx + 3'd1;
                o_uart_tx <= 1'b0;
                state     <= S_START;
              end else begin
                gap_cnt <= gap_cnt + 4'd1;
              end
            end
          end
          default: begin
            state     <= S_IDLE;
            o_ready   <= 1'b1;
            o_uart_tx <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_status_reporter.sv
// Scoreboard bench for status_reporter: a line monitor decodes UART bytes and o_done
// pulses and compares them against expectations queued by the stimulus.
module tb_status_reporter;

`ifdef STATUS_REPORTER_CHECKSUM_EN
  localparam int DONE0 = 200;
  localparam int DONE1 = 240;
`else
  localparam int DONE0 = 160;
  localparam int DONE1 = 192;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb0, stb1;
  logic [31:0] data0, data1;
  logic        rdy0, done0, tx0;
  logic        rdy1, done1, tx1;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         dq0[$];
  int         dq1[$];

  bit          act[2];
  int          kk[2];
  logic [63:0] samp[2];
  int          de;

  status_reporter #(.BAUD_CYCLES(4), .IDLE_GAP_BITS(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_stb(stb0), .i_data(data0),
    .o_ready(rdy0), .o_done(done0), .o_uart_tx(tx0)
  );

  status_reporter #(.BAUD_CYCLES(4), .IDLE_GAP_BITS(2)) dut_g (
    .i_clk(clk), .i_rst(rst), .i_stb(stb1), .i_data(data1),
    .o_ready(rdy1), .o_done(done1), .o_uart_tx(tx1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v === exp_v) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
  endtask

  function automatic int flen(input int i);
    return (i == 0) ? 40 : 48;
  endfunction

  task automatic check_frame(input int i);
    logic [7:0]  e, got;
    logic [63:0] ev;
    int          g;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      checks++;
      $display("FAIL unexpected_frame inst%0d: got samples %0h with nothing queued", i, samp[i]);
      return;
    end
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    got = '0;
    for (int b = 0; b < 8; b++) got[b] = samp[i][4*(b+1)+1];
    ev = '0;
    for (int j = 0; j < flen(i); j++) begin
      g = j / 4;
      ev[j] = (g == 0) ? 1'b0 : ((g <= 8) ? e[g-1] : 1'b1);
    end
    chk((i == 0) ? "rx_byte0" : "rx_byte1", 64'(got), 64'(e));
    chk((i == 0) ? "rx_frame0" : "rx_frame1", samp[i], ev);
  endtask

  task automatic mon_line(input int i, input logic tx);
    if (!act[i] && tx == 1'b0) begin
      act[i]  = 1'b1;
      kk[i]   = 0;
      samp[i] = '0;
    end
    if (act[i]) begin
      samp[i][kk[i]] = tx;
      kk[i]++;
      if (kk[i] == flen(i)) begin
        check_frame(i);
        act[i] = 1'b0;
      end
    end
  endtask

  // Line and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      act[0] = 1'b0;
      act[1] = 1'b0;
    end else begin
      mon_line(0, tx0);
      mon_line(1, tx1);
      if (done0) begin
        if (dq0.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done0: pulse at cycle %0d with none expected", cyc);
        end else begin
          de = dq0.pop_front();
          chk("done0_cycle", 64'(cyc), 64'(de));
          chk("ready_at_done0", 64'(rdy0), 64'd1);
        end
      end
      if (done1) begin
        if (dq1.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done1: pulse at cycle %0d with none expected", cyc);
        end else begin
          de = dq1.pop_front();
          chk("done1_cycle", 64'(cyc), 64'(de));
          chk("ready_at_done1", 64'(rdy1), 64'd1);
        end
      end
    end
  end

  task automatic push0(input logic [7:0] b0, b1, b2, b3, cs);
    q0.push_back(b0); q0.push_back(b1); q0.push_back(b2); q0.push_back(b3);
`ifdef STATUS_REPORTER_CHECKSUM_EN
    q0.push_back(cs);
`endif
  endtask

  task automatic push1(input logic [7:0] b0, b1, b2, b3, cs);
    q1.push_back(b0); q1.push_back(b1); q1.push_back(b2); q1.push_back(b3);
`ifdef STATUS_REPORTER_CHECKSUM_EN
    q1.push_back(cs);
`endif
  endtask

  task automatic issue0(input logic [31:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    while (!rdy0 && n < 1000) begin @(negedge clk); n++; end
    chk("ready_before_accept0", 64'(rdy0), 64'd1);
    stb0 = 1'b1; data0 = d;
    @(posedge clk); #1;
    stb0 = 1'b0; data0 = 32'hFFFF_FFFF;
    acc = cyc;
  endtask

  task automatic issue1(input logic [31:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    while (!rdy1 && n < 1000) begin @(negedge clk); n++; end
    chk("ready_before_accept1", 64'(rdy1), 64'd1);
    stb1 = 1'b1; data1 = d;
    @(posedge clk); #1;
    stb1 = 1'b0; data1 = 32'hFFFF_FFFF;
    acc = cyc;
  endtask

  task automatic wait_empty(input int i);
    int n = 0;
    while (((i == 0) ? dq0.size() : dq1.size()) != 0 && n < 2000) begin @(negedge clk); n++; end
    chk((i == 0) ? "done0_seen" : "done1_seen", 64'((i == 0) ? dq0.size() : dq1.size()), 64'd0);
  endtask

  initial begin
    int a, a2, n;
    stb0 = 1'b0; data0 = '0; stb1 = 1'b0; data1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx0", 64'(tx0), 64'd1);
    chk("reset_ready0", 64'(rdy0), 64'd1);
    chk("reset_done0", 64'(done0), 64'd0);
    chk("reset_tx1", 64'(tx1), 64'd1);
    rst = 1'b0;

    // Basic frame with a dropped load request at cycle 80
    push0(8'hA5, 8'hC3, 8'h0F, 8'h81, 8'hE8);
    issue0(32'hA5C3_0F81, a);
    dq0.push_back(a + DONE0 - 1);
    while (cyc < a + 79) @(negedge clk);
    chk("ready_busy0", 64'(rdy0), 64'd0);
    stb0 = 1'b1; data0 = 32'h1234_5678;
    @(negedge clk);
    stb0 = 1'b0; data0 = 32'h0;

    // Request held across o_done: back-to-back frame
    while (cyc < a + 150) @(negedge clk);
    push0(8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    stb0 = 1'b1; data0 = 32'h1234_5678;
    n = 0;
    while (!rdy0 && n < 200) begin @(negedge clk); n++; end
    chk("ready_return0", 64'(rdy0), 64'd1);
    @(posedge clk); #1;
    stb0 = 1'b0; data0 = 32'h0;
    a2 = cyc;
    dq0.push_back(a2 + DONE0 - 1);
    chk("b2b_no_idle", 64'(a2), 64'(a + DONE0));

    // Reset mid byte 2 (0x56, bit 5 = 0)
    while (cyc < a2 + 105) @(negedge clk);
    chk("mid_byte2_tx0", 64'(tx0), 64'd0);
    #2; rst = 1'b1; #1;
    chk("abort_tx0", 64'(tx0), 64'd1);
    chk("abort_ready0", 64'(rdy0), 64'd1);
    chk("abort_done0", 64'(done0), 64'd0);
    q0.delete(); dq0.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    push0(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22);
    issue0(32'hDEAD_BEEF, a);
    dq0.push_back(a + DONE0 - 1);
    wait_empty(0);

    push0(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F);
    issue0(32'h0102_0408, a);
    dq0.push_back(a + DONE0 - 1);
    wait_empty(0);

    // Idle gap of 2 bit times after every stop bit
    push1(8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF);
    issue1(32'h0000_00FF, a);
    dq1.push_back(a + DONE1 - 1);
    while (cyc < a + 44) @(negedge clk);
    chk("gap_high1", 64'(tx1), 64'd1);
    while (cyc < a + 48) @(negedge clk);
    chk("gap_end_start1", 64'(tx1), 64'd0);
    wait_empty(1);

    repeat (10) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
